// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   Synchronizes raw push buttons and switches, debounces each button with a
//   per-button stable-cycle counter, and turns each accepted press into a
//   single-cycle strobe. The strobe carries a one-hot select of the pressed
//   button and a snapshot of the switches taken at the press.
//
// Ports
//   clock      : single rising-edge clock
//   i_rst_n    : asynchronous active-low reset
//   i_btn      : raw bouncing push buttons, 1 = pressed       [NB_BTN]
//   i_sw       : raw switches                                 [NB_SW]
//   o_btn      : one-hot select, non-zero only with o_valid   [NB_BTN]
//   o_sw_data  : switches captured with the last accepted press [NB_SW]
//   o_valid    : single-cycle strobe per accepted press
//
// Build option
//   INPUT_DEBOUNCER_BYPASS_EN : when defined, the debounce counters are removed
//   and the stable level follows the synchronized button directly.
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int NB_BTN          = 3,
  parameter int NB_SW           = 8,
  parameter int NB_CNT          = 20,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              i_rst_n,
  input  logic [NB_BTN-1:0] i_btn,
  input  logic [NB_SW-1:0]  i_sw,
  output logic [NB_BTN-1:0] o_btn,
  output logic [NB_SW-1:0]  o_sw_data,
  output logic              o_valid
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    EMIT         = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  // Isolates the lowest set bit: v & (-v).
  function automatic logic [NB_BTN-1:0] lowest_onehot(input logic [NB_BTN-1:0] v);
    return v & (~v + NB_BTN'(1));
  endfunction

  logic [NB_BTN-1:0] btn_meta_r;
  logic [NB_BTN-1:0] btn_sync_r;
  logic [NB_SW-1:0]  sw_meta_r;
  logic [NB_SW-1:0]  sw_sync_r;
  logic [NB_BTN-1:0] stable_s;
  logic [NB_BTN-1:0] stable_d_r;
  logic [NB_BTN-1:0] press_s;

  state_t            state_r;
  state_t            next_state_s;
  logic              valid_nx_s;
  logic [NB_BTN-1:0] btn_nx_s;
  logic [NB_SW-1:0]  sw_nx_s;

  // Two-flop synchronizers for every raw button and switch bit.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta_r <= '0;
      btn_sync_r <= '0;
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
    end else begin
      btn_meta_r <= i_btn;
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= i_sw;
      sw_sync_r  <= sw_meta_r;
    end
  end

`ifdef INPUT_DEBOUNCER_BYPASS_EN
  // Debounce removed: the stable level is the synchronized level.
  always_comb begin
    stable_s = btn_sync_r;
  end
`else
  // Counter value seen just before the DEBOUNCE_CYCLES-th mismatched edge.
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic [NB_CNT-1:0] cnt_r [NB_BTN];
  logic [NB_BTN-1:0] stable_r;

  // Per-button counter: counts consecutive mismatches and flips the stable
  // level on the last one; the clear at that point keeps it from wrapping.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_r <= '0;
      for (int i = 0; i < NB_BTN; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_BTN; i++) begin
        if (btn_sync_r[i] != stable_r[i]) begin
          if (cnt_r[i] == CNT_LAST) begin
            stable_r[i] <= ~stable_r[i];
            cnt_r[i]    <= '0;
          end else begin
            cnt_r[i] <= cnt_r[i] + NB_CNT'(1);
          end
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  // Expose the debounced level under a mode-independent name.
  always_comb begin
    stable_s = stable_r;
  end
`endif

  // Previous stable level, used to detect 0->1 press edges.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_d_r <= '0;
    end else begin
      stable_d_r <= stable_s;
    end
  end

  // Press event: rising edge of the stable level; releases produce nothing.
  always_comb begin
    press_s = stable_s & ~stable_d_r;
  end

  // FSM next state and next output values; outputs are registered below so
  // the strobe lines up with the EMIT state.
  always_comb begin
    next_state_s = state_r;
    valid_nx_s   = 1'b0;
    btn_nx_s     = '0;
    sw_nx_s      = o_sw_data;
    case (state_r)
      IDLE: begin
        if (|press_s) begin
          next_state_s = EMIT;
          valid_nx_s   = 1'b1;
          btn_nx_s     = lowest_onehot(press_s);
          sw_nx_s      = sw_sync_r;
        end else begin
          next_state_s = IDLE;
        end
      end
      EMIT: begin
        next_state_s = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // Presses arriving here are dropped; wait for every button up.
        if (stable_s == '0) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_RELEASE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      o_valid   <= 1'b0;
      o_btn     <= '0;
      o_sw_data <= '0;
    end else begin
      state_r   <= next_state_s;
      o_valid   <= valid_nx_s;
      o_btn     <= btn_nx_s;
      o_sw_data <= sw_nx_s;
    end
  end

endmodule
